// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: bus widths, state encoding,
// timeout default and the bus command payload.
package mem_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 8'd255;

  // Arbiter states
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_IF_BUSY  = 2'd1;
  localparam logic [STATE_W-1:0] ST_MEM_BUSY = 2'd2;

  // Payload presented on the shared memory bus
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Instruction fetches are always full-word reads
  function automatic bus_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.sel   = {SEL_W{1'b1}};
    c.addr  = addr;
    c.wdata = '0;
    return c;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and shared memory bus around mem_arb.
interface mem_arb_if;
  import mem_arb_pkg::*;

  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;

  // Data-access port
  logic              mem_req;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  // Shared memory bus
  logic              bus_req;
  logic              bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  // Pipeline stall requests
  logic              stallreq_if;
  logic              stallreq_mem;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_ack, if_err,
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_err,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack,
    output stallreq_if, stallreq_mem
  );

  // Pipeline and memory-slave side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_ack, if_err,
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_err,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_rdata, bus_ack,
    input  stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/mem_arb.sv
// Fixed-priority arbiter sharing one memory bus between instruction fetch
// and data access, with a per-transaction timeout and fetch cancellation.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  logic [STATE_W-1:0] state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               drop_q, drop_n;
  logic               breq_q, breq_n;
  bus_cmd_t           cmd_q, cmd_n;

  logic [DATA_W-1:0]  if_rdata_q, if_rdata_n;
  logic               if_ack_q, if_ack_n;
  logic               if_err_q, if_err_n;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_n;
  logic               mem_ack_q, mem_ack_n;
  logic               mem_err_q, mem_err_n;

  logic               if_elig;
  logic               mem_elig;
  logic               timed_out;
  logic               flushed;
  logic [DATA_W-1:0]  done_data;

  // State, counter, payload and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      breq_q      <= 1'b0;
      cmd_q       <= '0;
      if_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      drop_q      <= drop_n;
      breq_q      <= breq_n;
      cmd_q       <= cmd_n;
      if_rdata_q  <= if_rdata_n;
      if_ack_q    <= if_ack_n;
      if_err_q    <= if_err_n;
      mem_rdata_q <= mem_rdata_n;
      mem_ack_q   <= mem_ack_n;
      mem_err_q   <= mem_err_n;
    end
  end

  // Next-state, grant, completion and timeout decisions
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    drop_n      = drop_q;
    breq_n      = breq_q;
    cmd_n       = cmd_q;
    if_rdata_n  = if_rdata_q;
    if_ack_n    = 1'b0;
    if_err_n    = 1'b0;
    mem_rdata_n = mem_rdata_q;
    mem_ack_n   = 1'b0;
    mem_err_n   = 1'b0;

    // A master still seeing its ack this cycle must not be granted again
    mem_elig  = bus.mem_req & ~mem_ack_q;
    if_elig   = bus.if_req & ~if_ack_q & ~bus.if_flush;
    timed_out = (cnt_q == TIMEOUT);
    flushed   = drop_q | bus.if_flush;
    // bus_ack beats a coincident timeout; a timeout returns zero data
    done_data = bus.bus_ack ? bus.bus_rdata : '0;

    case (state_q)
      ST_IDLE: begin
        drop_n = 1'b0;
        if (mem_elig) begin
          state_n       = ST_MEM_BUSY;
          cnt_n         = '0;
          breq_n        = 1'b1;
          cmd_n.we      = bus.mem_we;
          cmd_n.sel     = bus.mem_sel;
          cmd_n.addr    = bus.mem_addr;
          cmd_n.wdata   = bus.mem_wdata;
        end else if (if_elig) begin
          state_n = ST_IF_BUSY;
          cnt_n   = '0;
          breq_n  = 1'b1;
          cmd_n   = fetch_cmd(bus.if_addr);
        end
      end

      ST_IF_BUSY: begin
        if (bus.bus_ack || timed_out) begin
          state_n = ST_IDLE;
          breq_n  = 1'b0;
          drop_n  = 1'b0;
          // A redirected fetch finishes on the bus but stays invisible
          if (!flushed) begin
            if_ack_n   = 1'b1;
            if_err_n   = ~bus.bus_ack;
            if_rdata_n = done_data;
          end
        end else begin
          cnt_n  = cnt_q + CNT_W'(1);
          drop_n = flushed;
        end
      end

      ST_MEM_BUSY: begin
        if (bus.bus_ack || timed_out) begin
          state_n     = ST_IDLE;
          breq_n      = 1'b0;
          mem_ack_n   = 1'b1;
          mem_err_n   = ~bus.bus_ack;
          mem_rdata_n = done_data;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        breq_n  = 1'b0;
        drop_n  = 1'b0;
      end
    endcase
  end

  // Registered outputs onto the interface
  assign bus.bus_req   = breq_q;
  assign bus.bus_we    = cmd_q.we;
  assign bus.bus_sel   = cmd_q.sel;
  assign bus.bus_addr  = cmd_q.addr;
  assign bus.bus_wdata = cmd_q.wdata;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_err   = mem_err_q;

  // Stall requests are combinational and forced low while in reset
  assign bus.stallreq_if  = ~rst & bus.if_req & ~if_ack_q;
  assign bus.stallreq_mem = ~rst & bus.mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level reference model with a
// per-cycle compare, a programmable bus slave and directed scenarios.
module tb_mem_arb;

  localparam logic [7:0] TO = 8'd4;

  logic clk = 1'b0;
  logic rst;

  mem_arb_if ifc ();

  mem_arb #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus slave ----------------
  int          slave_delay = 0;   // ack after this many bus_req cycles; -1 = never
  logic [31:0] slave_data  = '0;
  logic        force_ack   = 1'b0;

  initial begin
    int n;
    n = 0;
    ifc.bus_ack   = 1'b0;
    ifc.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        ifc.bus_ack = 1'b0;
        n = 0;
      end else if (ifc.bus_req) begin
        ifc.bus_ack   = (slave_delay >= 0) && (n == slave_delay);
        ifc.bus_rdata = slave_data;
        n++;
      end else begin
        ifc.bus_ack   = force_ack;
        ifc.bus_rdata = slave_data;
        n = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // owner: 0 = bus free, 1 = fetch in flight, 2 = data access in flight
  int          owner = 0;
  int          waited = 0;
  bit          cancelled = 1'b0;
  logic        e_bus_req = 0, e_we = 0;
  logic [3:0]  e_sel = '0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic        e_if_ack = 0, e_if_err = 0, e_mem_ack = 0, e_mem_err = 0;
  logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

  initial forever begin
    logic        prev_if_ack, prev_mem_ack, ok;
    logic [31:0] result;
    @(posedge clk or posedge rst);
    if (rst === 1'b1) begin
      owner = 0; waited = 0; cancelled = 1'b0;
      e_bus_req = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0;
      e_if_ack = 0; e_if_err = 0; e_mem_ack = 0; e_mem_err = 0;
      e_if_rdata = '0; e_mem_rdata = '0;
    end else begin
      prev_if_ack  = e_if_ack;
      prev_mem_ack = e_mem_ack;
      e_if_ack = 0; e_if_err = 0; e_mem_ack = 0; e_mem_err = 0;
      if (owner == 0) begin
        if (ifc.mem_req && !prev_mem_ack) begin
          owner = 2; waited = 0; e_bus_req = 1;
          e_we = ifc.mem_we; e_sel = ifc.mem_sel;
          e_addr = ifc.mem_addr; e_wdata = ifc.mem_wdata;
        end else if (ifc.if_req && !prev_if_ack && !ifc.if_flush) begin
          owner = 1; waited = 0; e_bus_req = 1;
          e_we = 0; e_sel = 4'hF; e_addr = ifc.if_addr; e_wdata = '0;
        end
      end else begin
        if (owner == 1 && ifc.if_flush) cancelled = 1'b1;
        if (ifc.bus_ack || waited == int'(TO)) begin
          ok     = ifc.bus_ack;
          result = ok ? ifc.bus_rdata : 32'h0;
          if (owner == 2) begin
            e_mem_ack = 1; e_mem_err = !ok; e_mem_rdata = result;
          end else if (!cancelled) begin
            e_if_ack = 1; e_if_err = !ok; e_if_rdata = result;
          end
          owner = 0; cancelled = 1'b0; e_bus_req = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("bus_req",      32'(ifc.bus_req),      32'(e_bus_req));
    check("bus_we",       32'(ifc.bus_we),       32'(e_we));
    check("bus_sel",      32'(ifc.bus_sel),      32'(e_sel));
    check("bus_addr",     ifc.bus_addr,          e_addr);
    check("bus_wdata",    ifc.bus_wdata,         e_wdata);
    check("if_ack",       32'(ifc.if_ack),       32'(e_if_ack));
    check("if_err",       32'(ifc.if_err),       32'(e_if_err));
    check("if_rdata",     ifc.if_rdata,          e_if_rdata);
    check("mem_ack",      32'(ifc.mem_ack),      32'(e_mem_ack));
    check("mem_err",      32'(ifc.mem_err),      32'(e_mem_err));
    check("mem_rdata",    ifc.mem_rdata,         e_mem_rdata);
    check("stallreq_if",  32'(ifc.stallreq_if),  32'(!rst && ifc.if_req && !e_if_ack));
    check("stallreq_mem", 32'(ifc.stallreq_mem), 32'(!rst && ifc.mem_req && !e_mem_ack));
  end

  // Ack pulse counters for scenario-level checks
  int if_ack_total = 0, mem_ack_total = 0;
  initial forever begin
    @(negedge clk);
    if (ifc.if_ack)  if_ack_total++;
    if (ifc.mem_ack) mem_ack_total++;
  end

  // ---------------- stimulus helpers ----------------
  int          req_cycles, if_acks, mem_acks, first_owner;
  logic        last_if_err, last_mem_err, first_we;
  logic [31:0] last_if_rdata, last_mem_rdata, first_addr, first_wdata;
  logic [3:0]  first_sel;

  // Hold requests until acked, releasing each one the edge after its ack
  task automatic run(input int budget);
    int  cyc;
    bit  seen, fa, ma;
    cyc = 0; seen = 0;
    req_cycles = 0; if_acks = 0; mem_acks = 0; first_owner = 0;
    while ((ifc.if_req || ifc.mem_req) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ifc.bus_req) begin
        req_cycles++;
        if (!seen) begin
          seen = 1; first_we = ifc.bus_we; first_sel = ifc.bus_sel;
          first_addr = ifc.bus_addr; first_wdata = ifc.bus_wdata;
        end
      end
      fa = ifc.if_ack; ma = ifc.mem_ack;
      if (ma) begin
        mem_acks++; last_mem_err = ifc.mem_err; last_mem_rdata = ifc.mem_rdata;
        if (first_owner == 0) first_owner = 2;
      end
      if (fa) begin
        if_acks++; last_if_err = ifc.if_err; last_if_rdata = ifc.if_rdata;
        if (first_owner == 0) first_owner = 1;
      end
      @(posedge clk); #1;
      if (fa) ifc.if_req = 1'b0;
      if (ma) ifc.mem_req = 1'b0;
    end
    if (ifc.if_req || ifc.mem_req) begin
      n_checks++; n_fail++;
      $display("FAIL run_budget: requests still pending after %0d cycles, expected completion", budget);
      ifc.if_req = 1'b0; ifc.mem_req = 1'b0;
    end
  endtask

  // Wait for the bus to go quiet, bounded
  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (ifc.bus_req && cyc < budget) begin
      @(posedge clk); #1; cyc++;
    end
    if (ifc.bus_req) begin
      n_checks++; n_fail++;
      $display("FAIL drain_budget: bus_req still high after %0d cycles, expected low", budget);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mem_start(input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
    ifc.mem_req = 1'b1; ifc.mem_we = we; ifc.mem_sel = sel;
    ifc.mem_addr = addr; ifc.mem_wdata = wdata;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base_if, base_mem;
    rst = 1'b1;
    ifc.if_req = 0; ifc.if_addr = '0; ifc.if_flush = 0;
    ifc.mem_req = 0; ifc.mem_we = 0; ifc.mem_sel = '0; ifc.mem_addr = '0; ifc.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus_req", 32'(ifc.bus_req), 32'h0);
    check("reset_if_rdata", ifc.if_rdata, 32'h0);
    check("reset_bus_addr", ifc.bus_addr, 32'h0);
    rst = 1'b0;

    // Lone fetch, slave acks in the first bus cycle
    slave_delay = 0; slave_data = 32'h3401_0020;
    ifc.if_req = 1; ifc.if_addr = 32'h0000_0040;
    @(negedge clk);
    check("f1_c1_stall", 32'(ifc.stallreq_if), 32'h1);
    check("f1_c1_bus_req", 32'(ifc.bus_req), 32'h0);
    @(negedge clk);
    check("f1_c2_bus_req", 32'(ifc.bus_req), 32'h1);
    check("f1_c2_bus_we", 32'(ifc.bus_we), 32'h0);
    check("f1_c2_bus_sel", 32'(ifc.bus_sel), 32'hF);
    check("f1_c2_bus_addr", ifc.bus_addr, 32'h0000_0040);
    @(negedge clk);
    check("f1_c3_if_ack", 32'(ifc.if_ack), 32'h1);
    check("f1_c3_if_err", 32'(ifc.if_err), 32'h0);
    check("f1_c3_if_rdata", ifc.if_rdata, 32'h3401_0020);
    check("f1_c3_stall", 32'(ifc.stallreq_if), 32'h0);
    @(posedge clk); #1;
    ifc.if_req = 0;
    drain(20);

    // Simultaneous fetch and store: store goes first
    slave_delay = 1; slave_data = 32'h1234_5678;
    base_if = if_ack_total; base_mem = mem_ack_total;
    ifc.if_req = 1; ifc.if_addr = 32'h0000_0044;
    mem_start(1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
    run(40);
    check("both_first_owner", 32'(first_owner), 32'd2);
    check("both_store_we", 32'(first_we), 32'h1);
    check("both_store_sel", 32'(first_sel), 32'h3);
    check("both_store_addr", first_addr, 32'h0000_0100);
    check("both_store_wdata", first_wdata, 32'hDEAD_BEEF);
    check("both_if_rdata", last_if_rdata, 32'h1234_5678);
    drain(20);
    check("both_if_pulses", 32'(if_ack_total - base_if), 32'd1);
    check("both_mem_pulses", 32'(mem_ack_total - base_mem), 32'd1);

    // Slave never answers: abort after TIMEOUT
    slave_delay = -1;
    mem_start(1'b0, 4'hF, 32'h0000_0200, 32'h0);
    run(40);
    check("to_req_cycles", 32'(req_cycles), 32'd5);
    check("to_mem_acks", 32'(mem_acks), 32'd1);
    check("to_mem_err", 32'(last_mem_err), 32'h1);
    check("to_mem_rdata", last_mem_rdata, 32'h0);
    drain(20);

    // Ack on the very cycle the counter reaches TIMEOUT
    slave_delay = 4; slave_data = 32'hCAFE_F00D;
    mem_start(1'b0, 4'hF, 32'h0000_0204, 32'h0);
    run(40);
    check("edge_req_cycles", 32'(req_cycles), 32'd5);
    check("edge_mem_err", 32'(last_mem_err), 32'h0);
    check("edge_mem_rdata", last_mem_rdata, 32'hCAFE_F00D);
    drain(20);

    // Flush during a fetch: bus completes, fetch result is dropped
    slave_delay = 3; slave_data = 32'h7777_0000;
    base_if = if_ack_total;
    ifc.if_req = 1; ifc.if_addr = 32'h0000_0060;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("flush_in_busy", 32'(ifc.bus_req), 32'h1);
    ifc.if_flush = 1; ifc.if_req = 0;
    @(posedge clk); #1;
    ifc.if_flush = 0;
    drain(20);
    check("flush_no_ack", 32'(if_ack_total - base_if), 32'd0);
    check("flush_rdata_kept", ifc.if_rdata, 32'h1234_5678);
    slave_delay = 0; slave_data = 32'hA5A5_0080;
    ifc.if_req = 1; ifc.if_addr = 32'h0000_0080;
    run(40);
    check("refetch_acks", 32'(if_acks), 32'd1);
    check("refetch_err", 32'(last_if_err), 32'h0);
    check("refetch_rdata", last_if_rdata, 32'hA5A5_0080);
    drain(20);

    // Stray bus_ack while idle must be ignored
    base_if = if_ack_total; base_mem = mem_ack_total;
    force_ack = 1;
    @(posedge clk); #1;
    force_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_no_if_ack", 32'(if_ack_total - base_if), 32'd0);
    check("stray_no_mem_ack", 32'(mem_ack_total - base_mem), 32'd0);
    check("stray_no_bus_req", 32'(ifc.bus_req), 32'h0);

    // Reset in the middle of a data access
    slave_delay = -1;
    mem_start(1'b0, 4'hF, 32'h0000_0300, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(ifc.bus_req), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_bus_req", 32'(ifc.bus_req), 32'h0);
    check("rst_bus_addr", ifc.bus_addr, 32'h0);
    check("rst_mem_rdata", ifc.mem_rdata, 32'h0);
    check("rst_if_rdata", ifc.if_rdata, 32'h0);
    check("rst_stall_mem", 32'(ifc.stallreq_mem), 32'h0);
    ifc.mem_req = 0;
    base_mem = mem_ack_total;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_ack", 32'(mem_ack_total - base_mem), 32'd0);
    slave_delay = 0; slave_data = 32'h5555_AAAA;
    mem_start(1'b0, 4'hF, 32'h0000_0304, 32'h0);
    run(40);
    check("rst_reissue_acks", 32'(mem_acks), 32'd1);
    check("rst_reissue_err", 32'(last_mem_err), 32'h0);
    check("rst_reissue_rdata", last_mem_rdata, 32'h5555_AAAA);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
